// File: rtl/conv_adder_tree_pkg.sv
// Shared constants and sizing helpers for the convolution adder tree.
package conv_pkg;

  localparam int unsigned BITWIDTH     = 8;
  localparam int unsigned FILTER_WIDTH = 3;

  function automatic int unsigned tree_levels(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned sum_width(input int unsigned bw, input int unsigned n);
    return bw + $clog2(n);
  endfunction

  // Element count after k halvings, rounding up for the pass-through odd element.
  function automatic int unsigned level_count(input int unsigned n, input int unsigned k);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/conv_adder_tree_level.sv
// One registered pairwise reduction level of the adder tree.
module adder_tree_level #(
  parameter int unsigned in_count  = 9,
  parameter int unsigned in_width  = 8,
  parameter int unsigned out_width = 12
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     en,
  input  logic                                     in_valid,
  input  logic [in_count*in_width-1:0]             din,
  output logic                                     out_valid,
  output logic [((in_count+1)/2)*out_width-1:0]    dout
);

  localparam int unsigned out_count = (in_count + 1) / 2;

  logic [out_count*out_width-1:0] nxt;

  for (genvar i = 0; i < in_count / 2; i++) begin : g_pair
    assign nxt[i*out_width +: out_width] =
      out_width'(din[(2*i)*in_width +: in_width]) +
      out_width'(din[(2*i+1)*in_width +: in_width]);
  end

  if (in_count % 2 != 0) begin : g_odd
    assign nxt[(out_count-1)*out_width +: out_width] =
      out_width'(din[(in_count-1)*in_width +: in_width]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      dout      <= nxt;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/conv_adder_tree.sv
// Registered adder tree reducing one convolution window to a sum, with global stall backpressure.
// Optional clamp of the final sum to the product width: define CONV_ADDER_SAT_EN.
import conv_pkg::*;

module conv_adder_tree #(
  parameter int unsigned bitwidth    = BITWIDTH,
  parameter int unsigned filterWidth = FILTER_WIDTH,
  parameter int unsigned sumWidth    = sum_width(bitwidth, filterWidth*filterWidth),
  parameter int unsigned countWidth  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [bitwidth-1:0]   products [0:filterWidth*filterWidth-1],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [sumWidth-1:0]   sum_out,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic                  sat_flag,
  output logic [countWidth-1:0] result_count
);

  localparam int unsigned filterSize = filterWidth * filterWidth;
  localparam int unsigned L          = tree_levels(filterSize);

  logic                           en;
  logic [filterSize*bitwidth-1:0] flat;
  logic [sumWidth-1:0]            full_sum;

  always_comb begin
    flat = '0;
    for (int unsigned i = 0; i < filterSize; i++) flat[i*bitwidth +: bitwidth] = products[i];
  end

  // The last level register doubles as the output register, so a full output stalls everything.
  assign en       = ~sum_valid | sum_ready;
  assign in_ready = en;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned IN_N  = level_count(filterSize, k);
    localparam int unsigned OUT_N = level_count(filterSize, k + 1);
    localparam int unsigned IN_W  = (k == 0) ? bitwidth : sumWidth;

    logic [IN_N*IN_W-1:0]      din;
    logic                      vin;
    logic [OUT_N*sumWidth-1:0] dout;
    logic                      vout;

    if (k == 0) begin : g_src
      assign din = flat;
      assign vin = in_valid & en;
    end else begin : g_src
      assign din = g_lvl[k-1].dout;
      assign vin = g_lvl[k-1].vout;
    end

    adder_tree_level #(
      .in_count  (IN_N),
      .in_width  (IN_W),
      .out_width (sumWidth)
    ) u_level (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .in_valid  (vin),
      .din       (din),
      .out_valid (vout),
      .dout      (dout)
    );
  end

  assign full_sum  = g_lvl[L-1].dout;
  assign sum_valid = g_lvl[L-1].vout;

`ifdef CONV_ADDER_SAT_EN
  localparam logic [sumWidth-1:0] SAT_MAX = sumWidth'((64'd1 << bitwidth) - 64'd1);

  // Clamp is a pure function of the output register, so it holds with sum_out under stall.
  always_comb begin
    sat_flag = (full_sum > SAT_MAX);
    sum_out  = sat_flag ? SAT_MAX : full_sum;
  end
`else
  assign sum_out  = full_sum;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_count <= '0;
    end else if (sum_valid && sum_ready) begin
      result_count <= result_count + countWidth'(1);
    end
  end

endmodule

// File: tb/tb_conv_adder_tree.sv
// Scoreboard bench for conv_adder_tree: expected sums queued at input transfer, checked at output.
module tb_conv_adder_tree;

  localparam int unsigned N = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  products [0:N-1];
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] sum_out;
  logic        sum_valid;
  logic        sum_ready = 1'b1;
  logic        sat_flag;
  logic [15:0] result_count;

  logic [7:0]  pv [0:N-1];
  logic [31:0] exp_q [$];
  logic        sat_q [$];
  int unsigned cyc_q [$];
  int unsigned cyc = 0;
  int unsigned n_out = 0;
  int unsigned lat = 0;
  int unsigned n_checks = 0;
  int unsigned n_fails = 0;

  conv_adder_tree #(
    .bitwidth    (8),
    .filterWidth (3),
    .countWidth  (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .products     (products),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sum_out      (sum_out),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready),
    .sat_flag     (sat_flag),
    .result_count (result_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model(output logic [31:0] s, output logic sat);
    int unsigned t;
    t = 0;
    for (int i = 0; i < N; i++) t += products[i];
    sat = 1'b0;
`ifdef CONV_ADDER_SAT_EN
    if (t > 255) begin
      t = 255;
      sat = 1'b1;
    end
`endif
    s = t;
  endfunction

  // Outputs and input transfers are sampled on the falling edge, between active edges.
  always @(negedge clock) begin
    logic [31:0] s;
    logic        st;
    if (reset) begin
      if (sum_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, sum_valid}, 32'd0);
        end else begin
          check("sum", {20'd0, sum_out}, exp_q[0]);
          check("sat", {31'd0, sat_flag}, {31'd0, sat_q[0]});
          if (sum_ready) begin
            void'(exp_q.pop_front());
            void'(sat_q.pop_front());
            lat = cyc - cyc_q.pop_front();
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        model(s, st);
        exp_q.push_back(s);
        sat_q.push_back(st);
        cyc_q.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    sat_q.delete();
    cyc_q.delete();
    n_out = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic send();
    int unsigned t;
    t = 0;
    for (int i = 0; i < N; i++) products[i] = pv[i];
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int unsigned target, input int unsigned bound);
    int unsigned t;
    t = 0;
    while (n_out < target && t < bound) begin
      @(posedge clock);
      t++;
    end
    #1 check("drain_count", n_out, target);
  endtask

  initial begin
    int unsigned start;
    for (int i = 0; i < N; i++) products[i] = '0;

    do_reset();
    check("rst_sum_out", {20'd0, sum_out}, 32'd0);
    check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("rst_sat", {31'd0, sat_flag}, 32'd0);
    check("rst_count", {16'd0, result_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single window 9..1, sum 45
    for (int i = 0; i < N; i++) pv[i] = 8'(9 - i);
    send();
    wait_out(1, 20);
    check("t1_latency", lat, 32'd4);
    check("t1_valid_one_cycle", {31'd0, sum_valid}, 32'd0);
    check("t1_count", {16'd0, result_count}, 32'd1);

    // All products at maximum
    do_reset();
    for (int i = 0; i < N; i++) pv[i] = 8'd255;
    send();
    wait_out(1, 20);

    // Ten back-to-back windows
    do_reset();
    @(posedge clock);
    #1 start = cyc;
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < N; i++) pv[i] = 8'(w + 1);
      send();
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    end
    wait_out(10, 30);
    check("b2b_cycles", cyc - start, 32'd14);
    check("b2b_count", {16'd0, result_count}, 32'd10);

    // Output stalled for six cycles while five windows stream
    do_reset();
    @(posedge clock);
    #1 sum_ready = 1'b0;
    fork
      begin
        for (int w = 0; w < 5; w++) begin
          for (int i = 0; i < N; i++) pv[i] = 8'(w + 1);
          send();
        end
      end
      begin
        repeat (6) @(negedge clock);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_sum_valid", {31'd0, sum_valid}, 32'd1);
        check("stall_held_count", n_out, 32'd0);
        @(posedge clock);
        #1 sum_ready = 1'b1;
      end
    join
    wait_out(5, 40);
    check("stall_queue_empty", exp_q.size(), 32'd0);
    check("stall_count", {16'd0, result_count}, 32'd5);

    // Reset two cycles after an accepted window flushes it
    do_reset();
    for (int i = 0; i < N; i++) pv[i] = 8'(i * 3);
    send();
    @(posedge clock);
    do_reset();
    repeat (6) begin
      @(negedge clock);
      check("flush_no_valid", {31'd0, sum_valid}, 32'd0);
    end
    check("flush_count", {16'd0, result_count}, 32'd0);
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) pv[i] = 8'(20 + i);
    send();
    wait_out(1, 20);
    check("flush_latency", lat, 32'd4);

    // Counter wrap after 65535 transfers
    do_reset();
    for (int i = 0; i < N; i++) products[i] = 8'd1;
    @(posedge clock);
    #1 in_valid = 1'b1;
    repeat (65535) @(posedge clock);
    #1 in_valid = 1'b0;
    wait_out(65535, 20);
    check("wrap_pre", {16'd0, result_count}, 32'hFFFF);
    for (int i = 0; i < N; i++) pv[i] = 8'd7;
    send();
    wait_out(65536, 20);
    check("wrap_post", {16'd0, result_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
